fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_ctrl_if.sv | 26 ++
 rtl/step_edge.sv | 26 ++
 rtl/fetch_ctrl.sv | 109 ++++++++++
 tb/tb_fetch_ctrl.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction fetch controller.
//   - fetch_state_e : FSM state encoding (IDLE, ADDR, WAIT, ISSUE, HALT)
//   - OPC_JMP/OPC_HLT : opcodes decoded from the top nibble of an instruction
//   - DEF_ADDR_W/DEF_DATA_W : default ROM address and instruction widths
package fetch_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 11;

  localparam logic [3:0] OPC_JMP = 4'hE;
  localparam logic [3:0] OPC_HLT = 4'hF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    WAIT  = 3'd2,
    ISSUE = 3'd3,
    HALT  = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: bus between the fetch controller and a synchronous ROM.
//   rom_addr : address, driven by the controller (master)
//   rom_data : read data, driven by the ROM (slave)
// Protocol: there is no valid/ready pair. The master presents rom_addr in a
// cycle; the ROM registers the word on that cycle's closing edge, so rom_data
// is valid during the following cycle. The master must hold rom_addr stable
// for that cycle.
interface fetch_ctrl_if #(
  parameter int ADDR_W = fetch_pkg::DEF_ADDR_W,
  parameter int DATA_W = fetch_pkg::DEF_DATA_W
);

  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;

  modport master (
    output rom_addr,
    input  rom_data
  );

  modport slave (
    input  rom_addr,
    output rom_data
  );

endinterface

// File: rtl/step_edge.sv
// step_edge: rising-edge detector for the (already debounced) step switch.
//   clk, reset : clock and synchronous active-high reset
//   step       : step switch level
//   step_rise  : one-cycle pulse in the cycle step first reads high
// step_q resets to 1 so that a switch held high through reset is not seen
// as a new press once reset drops.
module step_edge (
  input  logic clk,
  input  logic reset,
  input  logic step,
  output logic step_rise
);

  logic step_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      step_q <= 1'b1;
    end else begin
      step_q <= step;
    end
  end

  assign step_rise = step & ~step_q;

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: single-step / free-run instruction fetch controller.
//   clk, reset  : clock, synchronous active-high reset
//   step        : step switch level; each rising edge in IDLE fetches once
//   run         : free-run; fetches back-to-back while high
//   rom         : ROM bus (master side), rom_addr always equals pc
//   instr       : last fetched instruction, held until the next capture
//   instr_valid : one-cycle pulse while the new instr is issued
//   pc          : program counter
//   halted      : high once an HLT instruction has been issued
//   state       : current FSM state, exported for debug
// Fetch sequence: IDLE -> ADDR (address presented) -> WAIT (ROM data valid,
// captured on the closing edge) -> ISSUE (decode, pc update).
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              step,
  input  logic              run,
  fetch_ctrl_if.master      rom,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output fetch_state_e      state
);

  fetch_state_e state_next;
  logic         step_rise;
  logic [3:0]   opcode;

  step_edge u_step_edge (
    .clk       (clk),
    .reset     (reset),
    .step      (step),
    .step_rise (step_rise)
  );

  assign opcode       = instr[DATA_W-1 -: 4];
  assign rom.rom_addr = pc;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. step_rise only matters in IDLE, so edges seen during
  // a fetch are dropped rather than queued.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (step_rise || run) state_next = ADDR;
      ADDR:    state_next = WAIT;
      WAIT:    state_next = ISSUE;
      ISSUE: begin
        if (opcode == OPC_HLT) begin
          state_next = HALT;
        end else if (run) begin
          state_next = ADDR;
        end else begin
          state_next = IDLE;
        end
      end
      HALT:    state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    instr_valid = 1'b0;
    halted      = 1'b0;
    unique case (state)
      ISSUE:   instr_valid = 1'b1;
      HALT:    halted      = 1'b1;
      default: ;
    endcase
  end

  // Instruction capture: rom_data is valid during WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr <= '0;
    end else if (state == WAIT) begin
      instr <= rom.rom_data;
    end
  end

  // PC update on issue; increment wraps naturally at 2^ADDR_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= '0;
    end else if (state == ISSUE) begin
      if (opcode == OPC_JMP) begin
        pc <= instr[ADDR_W-1:0];
      end else if (opcode != OPC_HLT) begin
        pc <= pc + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;
  import fetch_pkg::*;

  localparam int AW = 4;
  localparam int DW = 11;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic          step;
  logic          run;
  logic [DW-1:0] instr;
  logic          instr_valid;
  logic [AW-1:0] pc;
  logic          halted;
  fetch_state_e  state;

  always #5 clk = ~clk;

  fetch_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) rom_bus ();

  fetch_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk         (clk),
    .reset       (reset),
    .step        (step),
    .run         (run),
    .rom         (rom_bus.master),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .halted      (halted),
    .state       (state)
  );

  // Synchronous ROM model.
  logic [DW-1:0] rom_mem [16];
  always @(posedge clk) rom_bus.rom_data <= rom_mem[rom_bus.rom_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int tests_run    = 0;
  int tests_failed = 0;
  int valid_cnt    = 0;
  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] mon_e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (instr_valid === 1'b1) begin
      valid_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("fetch_instr", 32'(instr), 32'(mon_e[DW-1:0]));
        check("fetch_pc", 32'(pc), 32'(mon_e[AW+DW-1:DW]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic expect_fetch(input logic [AW-1:0] a);
    exp_q.push_back({a, rom_mem[a]});
  endtask

  task automatic fill_rom(input bit nop_only);
    for (int i = 0; i < 16; i++) begin
      if (nop_only) rom_mem[i] = {4'h0, 7'($urandom_range(0, 127))};
      else          rom_mem[i] = {4'($urandom_range(1, 13)), 7'($urandom_range(1, 127))};
    end
  endtask

  // Raise run and wait for n instr_valid pulses; optionally check 3-cycle
  // spacing and drop run at the last issue.
  task automatic run_fetches(input int n, input bit chk_gap, input bit keep_run);
    int base;
    int seen;
    int last;
    base = valid_cnt;
    seen = 0;
    last = -1;
    run  = 1'b1;
    for (int t = 0; t < 300 && seen < n; t++) begin
      tick();
      if (valid_cnt != base + seen) begin
        seen = valid_cnt - base;
        if (chk_gap && last >= 0) check("run_gap", 32'(cyc - last), 32'd3);
        last = cyc;
      end
    end
    if (seen != n) check("run_timeout", 32'(seen), 32'(n));
    if (!keep_run) run = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int v0;
    reset = 1'b1;
    step  = 1'b1;
    run   = 1'b0;
    fill_rom(1'b0);

    // Reset state, step held high through reset.
    tick();
    tick();
    check("rst_state", 32'(state), 32'(IDLE));
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_instr", 32'(instr), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    reset = 1'b0;
    repeat (5) tick();
    check("held_step_no_fetch", 32'(valid_cnt), 32'd0);

    // Single step, then held for 20 cycles.
    step = 1'b0;
    tick();
    tick();
    rom_mem[0] = 11'h001;
    valid_cnt  = 0;
    expect_fetch(4'd0);
    step = 1'b1;
    tick();
    check("step_addr", 32'(state), 32'(ADDR));
    check("step_valid_n1", 32'(instr_valid), 32'd0);
    tick();
    check("step_wait", 32'(state), 32'(WAIT));
    tick();
    check("step_valid_n3", 32'(instr_valid), 32'd1);
    check("step_instr", 32'(instr), 32'h001);
    tick();
    check("step_pc_n4", 32'(pc), 32'd1);
    check("step_valid_n4", 32'(instr_valid), 32'd0);
    repeat (16) tick();
    check("step_held_one_fetch", 32'(valid_cnt), 32'd1);
    step = 1'b0;
    tick();

    // Step edge during WAIT is ignored.
    v0 = valid_cnt;
    expect_fetch(4'd1);
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    step = 1'b1;
    repeat (4) tick();
    check("wait_edge_one_fetch", 32'(valid_cnt - v0), 32'd1);
    check("wait_edge_pc", 32'(pc), 32'd2);

    // Reset in WAIT discards the in-flight fetch (step still high).
    step = 1'b0;
    tick();
    step = 1'b1;
    v0 = valid_cnt;
    tick();
    tick();
    check("midrst_in_wait", 32'(state), 32'(WAIT));
    reset = 1'b1;
    tick();
    check("midrst_state", 32'(state), 32'(IDLE));
    check("midrst_pc", 32'(pc), 32'd0);
    check("midrst_instr", 32'(instr), 32'd0);
    check("midrst_valid", 32'(instr_valid), 32'd0);
    reset = 1'b0;
    repeat (6) tick();
    check("midrst_no_valid", 32'(valid_cnt - v0), 32'd0);
    step = 1'b0;

    // Free-run over the whole ROM with wrap.
    fill_rom(1'b1);
    do_reset();
    for (int i = 0; i < 19; i++) expect_fetch(4'(i));
    run_fetches(19, 1'b1, 1'b0);
    repeat (5) tick();
    check("wrap_idle", 32'(state), 32'(IDLE));
    check("wrap_pc", 32'(pc), 32'd3);
    check("wrap_drained", 32'(exp_q.size()), 32'd0);

    // Run dropped mid-fetch: current fetch completes, then IDLE.
    v0 = valid_cnt;
    expect_fetch(4'd3);
    run = 1'b1;
    tick();
    run = 1'b0;
    repeat (6) tick();
    check("run_drop_one_fetch", 32'(valid_cnt - v0), 32'd1);
    check("run_drop_idle", 32'(state), 32'(IDLE));

    // Jump from address 2 to 5.
    fill_rom(1'b1);
    rom_mem[2] = 11'h705;
    do_reset();
    for (int i = 0; i < 3; i++) expect_fetch(4'(i));
    run_fetches(3, 1'b1, 1'b1);
    tick();
    check("jmp_pc", 32'(pc), 32'd5);
    check("jmp_rom_addr", 32'(rom_bus.rom_addr), 32'd5);
    expect_fetch(4'd5);
    expect_fetch(4'd6);
    run_fetches(2, 1'b1, 1'b0);
    repeat (4) tick();

    // Halt at address 3; absorbing until reset.
    fill_rom(1'b1);
    rom_mem[3] = 11'h780;
    do_reset();
    for (int i = 0; i < 4; i++) expect_fetch(4'(i));
    run = 1'b1;
    for (int t = 0; t < 60 && halted !== 1'b1; t++) tick();
    check("hlt_halted", 32'(halted), 32'd1);
    check("hlt_state", 32'(state), 32'(HALT));
    check("hlt_pc", 32'(pc), 32'd3);
    v0 = valid_cnt;
    for (int t = 0; t < 30; t++) begin
      step = t[1];
      tick();
    end
    check("hlt_no_valid", 32'(valid_cnt - v0), 32'd0);
    check("hlt_still_halted", 32'(halted), 32'd1);
    check("hlt_pc_hold", 32'(pc), 32'd3);
    run  = 1'b0;
    step = 1'b0;
    do_reset();
    check("hlt_rst_halted", 32'(halted), 32'd0);
    check("hlt_rst_state", 32'(state), 32'(IDLE));
    check("hlt_rst_pc", 32'(pc), 32'd0);

    // run and step_rise together: one fetch.
    tick();
    v0 = valid_cnt;
    expect_fetch(4'd0);
    step = 1'b1;
    run  = 1'b1;
    tick();
    run = 1'b0;
    repeat (6) tick();
    check("run_step_one_fetch", 32'(valid_cnt - v0), 32'd1);
    step = 1'b0;
    tick();

    check("queue_drained", 32'(exp_q.size()), 32'd0);

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
